sram_ecc_ctrl_128x256: RTL and testbench
========================================

SRAM_ECC_CTRL_128X256 -- requirements
Module: sram_ecc_ctrl_128x256

Interface
REQ-001 SHALL declare parameter Depth, default 128, meaning the number of SRAM words.
REQ-002 SHALL declare parameter Lanes, default 8, meaning the number of 32-bit data lanes, each stored as a 39-bit SECDED codeword.
REQ-003 SHALL provide the following ports, listed as name, direction, width, meaning:
  clk_i  in  1  single clock.
  rst_i  in  1  reset, asynchronous, active-high.
  req_i  in  1  host request.
  gnt_o  out  1  request accepted this cycle (req_i & gnt_o).
  we_i  in  1  1 = write, 0 = read.
  addr_i  in  7  word address.
  wdata_i  in  256  write data; lane i = [32i+31:32i].
  wmask_i  in  8  per-lane write enable.
  rvalid_o  out  1  read response valid, one-cycle pulse.
  rdata_o  out  256  corrected read data.
  rerr_o  out  2  [0] correctable error in any lane, [1] uncorrectable error in any lane; valid with rvalid_o.
  init_i  in  1  request a full memory clear.
  init_done_o  out  1  memory initialised, ready for host traffic.
  corr_cnt_o  out  8  saturating count of read responses with rerr_o[0]=1.
  sram_req_o  out  1  SRAM macro request.
  sram_write_o  out  1  SRAM macro write.
  sram_addr_o  out  7  SRAM macro address.
  sram_wmask_o  out  8  SRAM macro lane mask.
  sram_wdata_o  out  312  SRAM macro write data; lane i = [39i+38:39i].
  sram_rdata_i  in  312  SRAM macro read data, valid the cycle after a read request.

Function
REQ-004 SHALL encode each lane with prim_secded_39_32_enc: data in bits [31:0] of the lane codeword, check bits in [38:32].
REQ-005 SHALL decode each lane with prim_secded_39_32_dec.
REQ-006 SHALL implement a state machine with states INIT and IDLE.
REQ-007 In INIT, SHALL issue one SRAM write per cycle to addresses 0..Depth-1 in ascending order, with sram_wmask_o=8'hFF and sram_wdata_o=0 (a valid all-zero codeword).
REQ-008 SHALL drive gnt_o=0 and init_done_o=0 while in INIT.
REQ-009 After the write to address Depth-1, SHALL move to IDLE and set init_done_o=1 from the next cycle; INIT therefore lasts exactly Depth cycles.
REQ-010 In IDLE, SHALL hold gnt_o=1; host requests pass combinationally to the SRAM port in the same cycle.
REQ-011 Accepted write: SHALL drive sram_req_o=1, sram_write_o=1, sram_wmask_o=wmask_i and the encoded wdata_i.
REQ-012 A write with wmask_i=0 SHALL be accepted but SHALL NOT assert sram_req_o.
REQ-013 Writes SHALL produce no response.
REQ-014 Accepted read at cycle T: SHALL drive sram_req_o=1, sram_write_o=0 at T; capture sram_rdata_i and decode at T+1; assert rvalid_o with registered rdata_o/rerr_o at T+2.
REQ-015 Reads SHALL be fully pipelined: back-to-back reads yield back-to-back rvalid_o pulses, in order.
REQ-016 rdata_o lane SHALL be the corrected data, or the raw stored data bits when that lane's error is uncorrectable.
REQ-017 rerr_o SHALL be the OR across lanes of each error class; both bits may be set together.
REQ-018 corr_cnt_o SHALL increment on each rvalid_o with rerr_o[0]=1 and saturate at 255.
REQ-019 init_i sampled high in IDLE SHALL move the block to INIT on the next cycle, restarting at address 0 and clearing corr_cnt_o.
REQ-020 A request presented in the same cycle as init_i SHALL still be granted.
REQ-021 Reads already in flight when INIT begins SHALL complete normally; INIT writes do not disturb pending SRAM read data.
REQ-022 init_i SHALL be ignored while in INIT.

Reset
REQ-023 Asserting rst_i SHALL immediately force state INIT with address 0, and drive gnt_o=0, init_done_o=0, rvalid_o=0, rdata_o=0, rerr_o=0, corr_cnt_o=0, sram_req_o=0.
REQ-024 Reset asserted mid-INIT or mid-read SHALL discard all progress; initialisation restarts from address 0 after release.
REQ-025 The first SRAM write after rst_i deasserts SHALL occur in the first clock edge cycle after release.

Verification
REQ-026 Release reset -> exactly 128 writes to addresses 0..127 with mask FF and data 0; init_done_o=1 and gnt_o=1 at cycle 129.
REQ-027 Write addr 5 with wdata lane 0 = 32'hDEADBEEF and mask 8'h01, then read addr 5 -> rvalid_o two cycles after grant, lane 0 = DEADBEEF, other lanes 0, rerr_o=0.
REQ-028 Flip 1 bit of lane 3 in the SRAM model, then read -> corrected data returned, rerr_o=2'b01, corr_cnt_o increments by 1; 300 such reads -> corr_cnt_o=255.
REQ-029 Flip 2 bits in lane 7, then read -> rerr_o[1]=1, lane 7 = raw stored data bits.
REQ-030 Four back-to-back reads, then init_i pulsed on the last grant -> four consecutive rvalid_o pulses in order, then 128 clearing writes, corr_cnt_o=0.
REQ-031 rst_i asserted at INIT address 60 -> outputs reset immediately; after release, clearing restarts from address 0.

Source files
------------

// File: rtl/sram_ecc_ctrl_128x256.sv
// SECDED-protected SRAM controller: Lanes x 32-bit data lanes, each stored as a
// 39-bit Hsiao codeword. After reset, or on an init_i request, the whole array
// is cleared to zero. Reads have a two-cycle latency and are fully pipelined.
module sram_ecc_ctrl_128x256 #(
   parameter int Depth = 128,
   parameter int Lanes = 8
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       req_i,
   output logic                       gnt_o,
   input  logic                       we_i,
   input  logic [$clog2(Depth)-1:0]   addr_i,
   input  logic [Lanes*32-1:0]        wdata_i,
   input  logic [Lanes-1:0]           wmask_i,
   output logic                       rvalid_o,
   output logic [Lanes*32-1:0]        rdata_o,
   output logic [1:0]                 rerr_o,
   input  logic                       init_i,
   output logic                       init_done_o,
   output logic [7:0]                 corr_cnt_o,
   output logic                       sram_req_o,
   output logic                       sram_write_o,
   output logic [$clog2(Depth)-1:0]   sram_addr_o,
   output logic [Lanes-1:0]           sram_wmask_o,
   output logic [Lanes*39-1:0]        sram_wdata_o,
   input  logic [Lanes*39-1:0]        sram_rdata_i
);

   localparam int AW = $clog2(Depth);
   localparam int DW = Lanes * 32;
   localparam int CW = Lanes * 39;

   // Hsiao (39,32) parity masks over the data bits; check bit k is lane bit 32+k.
   localparam logic [38:0] EncMask [7] = '{
      39'h002606BD25, 39'h00DEBA8050, 39'h00413D89AA, 39'h0031234ED1,
      39'h00C2C1323B, 39'h002DCC624C, 39'h0098505586
   };

   function automatic logic [38:0] prim_secded_39_32_enc(input logic [31:0] data);
      logic [38:0] cw;
      cw = {7'b0000000, data};
      for (int k = 0; k < 7; k++) begin
         cw[32+k] = ^(cw[31:0] & EncMask[k][31:0]);
      end
      return cw;
   endfunction

   // Returns {uncorrectable, correctable, data}; data is raw when uncorrectable.
   function automatic logic [33:0] prim_secded_39_32_dec(input logic [38:0] cw);
      logic [6:0]  syn;
      logic [6:0]  col;
      logic [31:0] data;
      logic [1:0]  err;
      for (int k = 0; k < 7; k++) begin
         syn[k] = (^(cw[31:0] & EncMask[k][31:0])) ^ cw[32+k];
      end
      for (int j = 0; j < 32; j++) begin
         for (int k = 0; k < 7; k++) begin
            col[k] = EncMask[k][j];
         end
         data[j] = cw[j] ^ (syn == col);
      end
      err[0] = ^syn;
      err[1] = ~(^syn) & (|syn);
      data   = err[1] ? cw[31:0] : data;
      return {err, data};
   endfunction

   function automatic logic [CW-1:0] encode_word(input logic [DW-1:0] d);
      logic [CW-1:0] c;
      for (int l = 0; l < Lanes; l++) begin
         c[39*l +: 39] = prim_secded_39_32_enc(d[32*l +: 32]);
      end
      return c;
   endfunction

   // Returns {error classes ORed across lanes, corrected data word}.
   function automatic logic [DW+1:0] decode_word(input logic [CW-1:0] c);
      logic [33:0]   ld;
      logic [DW-1:0] d;
      logic [1:0]    err;
      err = 2'b00;
      for (int l = 0; l < Lanes; l++) begin
         ld            = prim_secded_39_32_dec(c[39*l +: 39]);
         d[32*l +: 32] = ld[31:0];
         err           = err | ld[33:32];
      end
      return {err, d};
   endfunction

   typedef enum logic [0:0] {StInit = 1'b0, StIdle = 1'b1} state_e;

   state_e          state_r;
   state_e          state_next_s;
   logic [AW-1:0]   init_addr_r;
   logic            init_last_s;
   logic            init_start_s;
   logic            rd_acc_s;
   logic            rd_pend_r;
   logic [DW+1:0]   dec_s;

   assign init_last_s  = (init_addr_r == AW'(Depth - 1));
   assign init_start_s = (state_r == StIdle) & init_i;
   assign dec_s        = decode_word(sram_rdata_i);

   // State register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_r <= StInit;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next state: INIT sweeps the array once, IDLE leaves only on init_i.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         StInit: begin
            if (init_last_s) state_next_s = StIdle;
            else             state_next_s = StInit;
         end
         StIdle: begin
            if (init_i) state_next_s = StInit;
            else        state_next_s = StIdle;
         end
         default: state_next_s = StInit;
      endcase
   end

   // Outputs: clearing writes in INIT, combinational host pass-through in IDLE.
   always_comb begin
      gnt_o        = 1'b0;
      init_done_o  = 1'b0;
      rd_acc_s     = 1'b0;
      sram_req_o   = 1'b0;
      sram_write_o = 1'b0;
      sram_addr_o  = {AW{1'b0}};
      sram_wmask_o = {Lanes{1'b0}};
      sram_wdata_o = {CW{1'b0}};
      case (state_r)
         StInit: begin
            sram_req_o   = ~rst_i;
            sram_write_o = 1'b1;
            sram_addr_o  = init_addr_r;
            sram_wmask_o = {Lanes{1'b1}};
         end
         StIdle: begin
            gnt_o        = 1'b1;
            init_done_o  = 1'b1;
            rd_acc_s     = req_i & ~we_i;
            sram_req_o   = req_i & (~we_i | (|wmask_i));
            sram_write_o = we_i;
            sram_addr_o  = addr_i;
            sram_wmask_o = we_i ? wmask_i : {Lanes{1'b1}};
            sram_wdata_o = encode_word(wdata_i);
         end
         default: begin
            gnt_o = 1'b0;
         end
      endcase
   end

   // Clearing address: restarts at 0 on every entry into INIT.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         init_addr_r <= {AW{1'b0}};
      end else if (init_start_s || (state_r == StInit && init_last_s)) begin
         init_addr_r <= {AW{1'b0}};
      end else if (state_r == StInit) begin
         init_addr_r <= init_addr_r + AW'(1);
      end
   end

   // Read pipeline: request at T, decode SRAM data at T+1, respond at T+2.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rd_pend_r <= 1'b0;
         rvalid_o  <= 1'b0;
         rdata_o   <= {DW{1'b0}};
         rerr_o    <= 2'b00;
      end else begin
         rd_pend_r <= rd_acc_s;
         rvalid_o  <= rd_pend_r;
         if (rd_pend_r) begin
            rdata_o <= dec_s[DW-1:0];
            rerr_o  <= dec_s[DW+1:DW];
         end
      end
   end

   // Correctable-error response counter: saturates, cleared on entry into INIT.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         corr_cnt_o <= 8'd0;
      end else if (init_start_s) begin
         corr_cnt_o <= 8'd0;
      end else if (rd_pend_r && dec_s[DW] && (corr_cnt_o != 8'hFF)) begin
         corr_cnt_o <= corr_cnt_o + 8'd1;
      end
   end

endmodule

// File: tb/tb_sram_ecc_ctrl_128x256.sv
// Directed bench for sram_ecc_ctrl_128x256 with a behavioural SRAM macro model.
module tb_sram_ecc_ctrl_128x256;

   typedef logic [311:0] v_t;
   typedef struct {
      int          cyc;
      logic [1:0]  err;
      logic [255:0] data;
   } rsp_t;

   logic         clk_i = 1'b0;
   logic         rst_i = 1'b1;
   logic         req_i = 1'b0;
   logic         gnt_o;
   logic         we_i = 1'b0;
   logic [6:0]   addr_i = 7'd0;
   logic [255:0] wdata_i = 256'd0;
   logic [7:0]   wmask_i = 8'd0;
   logic         rvalid_o;
   logic [255:0] rdata_o;
   logic [1:0]   rerr_o;
   logic         init_i = 1'b0;
   logic         init_done_o;
   logic [7:0]   corr_cnt_o;
   logic         sram_req_o;
   logic         sram_write_o;
   logic [6:0]   sram_addr_o;
   logic [7:0]   sram_wmask_o;
   logic [311:0] sram_wdata_o;
   logic [311:0] sram_rdata_i;

   logic         flip_req = 1'b0;
   logic [6:0]   flip_addr = 7'd0;
   logic [311:0] flip_mask = 312'd0;
   logic [311:0] mem [128];

   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;
   rsp_t rsp_q[$];

   sram_ecc_ctrl_128x256 dut (
      .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .gnt_o(gnt_o), .we_i(we_i),
      .addr_i(addr_i), .wdata_i(wdata_i), .wmask_i(wmask_i), .rvalid_o(rvalid_o),
      .rdata_o(rdata_o), .rerr_o(rerr_o), .init_i(init_i), .init_done_o(init_done_o),
      .corr_cnt_o(corr_cnt_o), .sram_req_o(sram_req_o), .sram_write_o(sram_write_o),
      .sram_addr_o(sram_addr_o), .sram_wmask_o(sram_wmask_o),
      .sram_wdata_o(sram_wdata_o), .sram_rdata_i(sram_rdata_i)
   );

   always #5 clk_i = ~clk_i;

   // Cycle counter used to time-stamp responses.
   always @(posedge clk_i) cyc <= cyc + 1;

   // SRAM macro model: lane-masked writes, registered reads, bench-injected bit flips.
   always @(posedge clk_i) begin
      if (flip_req) begin
         mem[flip_addr] <= mem[flip_addr] ^ flip_mask;
      end else if (sram_req_o) begin
         if (sram_write_o) begin
            for (int l = 0; l < 8; l++) begin
               if (sram_wmask_o[l]) mem[sram_addr_o][39*l +: 39] <= sram_wdata_o[39*l +: 39];
            end
         end else begin
            sram_rdata_i <= mem[sram_addr_o];
         end
      end
   end

   // Response monitor.
   always @(negedge clk_i) begin
      if (!rst_i && rvalid_o) rsp_q.push_back('{cyc, rerr_o, rdata_o});
   end

   task automatic chk(input string tag, input v_t act, input v_t exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic flip(input logic [6:0] a, input logic [311:0] m);
      flip_req = 1'b1; flip_addr = a; flip_mask = m;
      step();
      flip_req = 1'b0;
   endtask

   task automatic host_write(input logic [6:0] a, input logic [255:0] d, input logic [7:0] m);
      logic [255:0] ext;
      req_i = 1'b1; we_i = 1'b1; addr_i = a; wdata_i = d; wmask_i = m;
      @(negedge clk_i);
      for (int l = 0; l < 8; l++) ext[32*l +: 32] = sram_wdata_o[39*l +: 32];
      chk("wr_ctl", v_t'({gnt_o, sram_req_o, sram_write_o, sram_addr_o, sram_wmask_o}),
          v_t'({1'b1, |m, 1'b1, a, m}));
      chk("wr_data", v_t'(ext), v_t'(d));
      step();
      req_i = 1'b0; we_i = 1'b0; wmask_i = 8'd0;
   endtask

   task automatic host_read(input logic [6:0] a);
      req_i = 1'b1; we_i = 1'b0; addr_i = a;
      @(negedge clk_i);
      chk("rd_ctl", v_t'({gnt_o, sram_req_o, sram_write_o, sram_addr_o}), v_t'({1'b1, 1'b1, 1'b0, a}));
      step();
      req_i = 1'b0;
   endtask

   task automatic pop_rsp(input string tag, input int exp_cyc, input logic [255:0] d, input logic [1:0] e);
      rsp_t r;
      chk({tag, "_present"}, v_t'(rsp_q.size() != 0), v_t'(1'b1));
      if (rsp_q.size() != 0) begin
         r = rsp_q.pop_front();
         if (exp_cyc >= 0) chk({tag, "_cyc"}, v_t'(r.cyc), v_t'(exp_cyc));
         chk({tag, "_rsp"}, v_t'({r.err, r.data}), v_t'({e, d}));
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_ctl"}, v_t'({gnt_o, init_done_o, rvalid_o, rerr_o, corr_cnt_o, sram_req_o}), v_t'(1'b0));
      chk({tag, "_rdata"}, v_t'(rdata_o), v_t'(1'b0));
   endtask

   // Called at the start of the first INIT cycle; checks 128 clearing writes then IDLE.
   task automatic check_init_seq(input int pulse_at);
      for (int i = 0; i < 128; i++) begin
         init_i = (i == pulse_at);
         @(negedge clk_i);
         chk("init_ctl", v_t'({sram_req_o, sram_write_o, sram_addr_o, sram_wmask_o, gnt_o, init_done_o}),
             v_t'({1'b1, 1'b1, 7'(i), 8'hFF, 1'b0, 1'b0}));
         chk("init_wdata", sram_wdata_o, v_t'(1'b0));
         step();
      end
      init_i = 1'b0;
      @(negedge clk_i);
      chk("init_end", v_t'({gnt_o, init_done_o, sram_req_o}), v_t'({1'b1, 1'b1, 1'b0}));
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [255:0] exp_d;
      logic [311:0] fm;
      int t0;
      int good;

      // Reset state, then the full clear sequence.
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      chk_reset("reset");
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      check_init_seq(-1);

      // Masked-off write is accepted without touching the macro; then a lane-0 write.
      host_write(7'd5, {8{32'hFFFFFFFF}}, 8'h00);
      host_write(7'd5, 256'hDEADBEEF, 8'h01);
      rsp_q.delete();
      t0 = cyc;
      host_read(7'd5);
      repeat (3) step();
      pop_rsp("rd5", t0 + 2, 256'hDEADBEEF, 2'b00);

      // Single-bit error in lane 3: corrected, counted, then saturation.
      flip(7'd5, 312'd1 << (39*3 + 7));
      host_read(7'd5);
      repeat (3) step();
      pop_rsp("sbe", -1, 256'hDEADBEEF, 2'b01);
      chk("cnt_one", v_t'(corr_cnt_o), v_t'(8'd1));
      rsp_q.delete();
      req_i = 1'b1; we_i = 1'b0; addr_i = 7'd5;
      repeat (300) step();
      req_i = 1'b0;
      repeat (3) step();
      chk("sbe_count", v_t'(rsp_q.size()), v_t'(300));
      good = 0;
      foreach (rsp_q[i]) if (rsp_q[i].err == 2'b01 && rsp_q[i].data == 256'hDEADBEEF) good++;
      chk("sbe_all_ok", v_t'(good), v_t'(300));
      chk("cnt_sat", v_t'(corr_cnt_o), v_t'(8'd255));

      // Double error in lane 7 plus single error in lane 2 at one address.
      host_write(7'd9, {32'h12345678, 224'd0}, 8'h80);
      fm = 312'd0;
      fm[39*7 + 0] = 1'b1;
      fm[39*7 + 4] = 1'b1;
      fm[39*2 + 31] = 1'b1;
      flip(7'd9, fm);
      rsp_q.delete();
      host_read(7'd9);
      repeat (3) step();
      pop_rsp("dbe", -1, {32'h12345669, 224'd0}, 2'b11);
      chk("cnt_hold", v_t'(corr_cnt_o), v_t'(8'd255));

      // Four back-to-back reads, init_i on the last grant; init_i mid-INIT ignored.
      for (int i = 0; i < 4; i++) begin
         exp_d = 256'd0;
         exp_d[255:224] = 32'hB0B00000 + 32'(i);
         exp_d[31:0]    = 32'hA0A00000 + 32'(i);
         host_write(7'(10 + i), exp_d, 8'hFF);
      end
      rsp_q.delete();
      t0 = cyc;
      for (int i = 0; i < 4; i++) begin
         req_i = 1'b1; we_i = 1'b0; addr_i = 7'(10 + i); init_i = (i == 3);
         @(negedge clk_i);
         chk("b2b_gnt", v_t'({gnt_o, sram_req_o}), v_t'({1'b1, 1'b1}));
         step();
      end
      req_i = 1'b0;
      init_i = 1'b0;
      check_init_seq(50);
      for (int i = 0; i < 4; i++) begin
         exp_d = 256'd0;
         exp_d[255:224] = 32'hB0B00000 + 32'(i);
         exp_d[31:0]    = 32'hA0A00000 + 32'(i);
         pop_rsp("b2b", t0 + 2 + i, exp_d, 2'b00);
      end
      chk("cnt_cleared", v_t'(corr_cnt_o), v_t'(8'd0));

      // Reset with a read in flight discards it and restarts the clear.
      host_write(7'd20, 256'hCAFEF00D, 8'hFF);
      flip(7'd20, 312'd1 << (39 + 3));
      rsp_q.delete();
      host_read(7'd20);
      repeat (3) step();
      pop_rsp("sbe20", -1, 256'hCAFEF00D, 2'b01);
      chk("cnt_after_init", v_t'(corr_cnt_o), v_t'(8'd1));
      host_read(7'd20);
      rst_i = 1'b1;
      #1;
      chk_reset("rst_midread");
      step();
      step();
      rst_i = 1'b0;
      check_init_seq(-1);
      chk("flush", v_t'(rsp_q.size()), v_t'(0));

      // Reset at clearing address 60 restarts the clear from address 0.
      init_i = 1'b1;
      step();
      init_i = 1'b0;
      repeat (60) step();
      @(negedge clk_i);
      chk("at60", v_t'({sram_req_o, sram_addr_o}), v_t'({1'b1, 7'd60}));
      rst_i = 1'b1;
      #1;
      chk_reset("rst_midinit");
      step();
      step();
      rst_i = 1'b0;
      check_init_seq(-1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
